// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB TX line stage: SYNC, LSB-first serialize, bit stuff, NRZI, EOP (macro USB_TX_BITSTUFF_EN enables stuffing)
module usb_tx_serializer #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_to_sop,
    input  logic       tx_to_eop,
    input  logic       tx_to_valid,
    output logic       tx_to_ready,
    input  logic [7:0] tx_to_data,
    output logic       tx_dp,
    output logic       tx_dn,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_EOP_SE0 = 3'd3;
    localparam logic [2:0] ST_EOP_J   = 3'd4;

    // Registers describe the bit currently on the line; the next-state logic
    // picks the following bit so that every line output is a flop.
    logic [2:0] state, state_nxt;
    logic [7:0] hold_data, hold_data_nxt;
    logic       hold_eop, hold_eop_nxt;
    logic       hold_valid, hold_valid_nxt;
    logic       eop_taken, eop_taken_nxt;
    logic [7:0] shift_reg, shift_reg_nxt;
    logic       cur_eop, cur_eop_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       se0_second, se0_second_nxt;
    logic       line_j, line_j_nxt;
    logic       dp_nxt, dn_nxt, oe_nxt, underrun_nxt;
    logic       accept, stuff_due;
    logic       raw_valid, raw_bit, enc_base;
    logic [2:0] bit_cnt_inc;
`ifdef USB_TX_BITSTUFF_EN
    logic [2:0] ones_cnt, ones_nxt, ones_base;
`endif

    assign tx_to_ready = ~hold_valid & ~eop_taken & (state != ST_EOP_SE0) & (state != ST_EOP_J);
    assign tx_busy     = (state != ST_IDLE);
    assign accept      = tx_to_valid & tx_to_ready;
    assign bit_cnt_inc = bit_cnt + 3'd1;
`ifdef USB_TX_BITSTUFF_EN
    assign stuff_due   = (ones_cnt == 3'd6);
`else
    assign stuff_due   = 1'b0;
`endif

    // Choose the next line bit (sync, data, stuff or EOP) and encode it
    always_comb begin
        state_nxt      = state;
        hold_data_nxt  = hold_data;
        hold_eop_nxt   = hold_eop;
        hold_valid_nxt = hold_valid;
        eop_taken_nxt  = eop_taken;
        shift_reg_nxt  = shift_reg;
        cur_eop_nxt    = cur_eop;
        bit_cnt_nxt    = bit_cnt;
        se0_second_nxt = se0_second;
        line_j_nxt     = line_j;
        dp_nxt         = 1'b1;
        dn_nxt         = 1'b0;
        oe_nxt         = 1'b0;
        underrun_nxt   = 1'b0;
        raw_valid      = 1'b0;
        raw_bit        = 1'b0;
        enc_base       = line_j;
`ifdef USB_TX_BITSTUFF_EN
        ones_base      = ones_cnt;
        ones_nxt       = ones_cnt;
`endif
        // Bytes without sop arriving while idle are swallowed, not held
        if (accept && ((state != ST_IDLE) || tx_to_sop)) begin
            hold_data_nxt  = tx_to_data;
            hold_eop_nxt   = tx_to_eop;
            hold_valid_nxt = 1'b1;
            if (tx_to_eop) eop_taken_nxt = 1'b1;
        end
        case (state)
            ST_IDLE: begin
                line_j_nxt = 1'b1;
`ifdef USB_TX_BITSTUFF_EN
                ones_nxt   = 3'd0;
`endif
                if (accept && tx_to_sop) begin
                    state_nxt   = ST_SYNC;
                    bit_cnt_nxt = 3'd0;
                    raw_valid   = 1'b1;
                    raw_bit     = SYNC_PATTERN[0];
                    enc_base    = 1'b1;
`ifdef USB_TX_BITSTUFF_EN
                    ones_base   = 3'd0;
`endif
                end
            end
            ST_SYNC, ST_DATA: begin
                if (stuff_due) begin
                    // Stuffed zero: toggle the line, hold the shifter
                    line_j_nxt = ~line_j;
                    dp_nxt     = ~line_j;
                    dn_nxt     = line_j;
                    oe_nxt     = 1'b1;
`ifdef USB_TX_BITSTUFF_EN
                    ones_nxt   = 3'd0;
`endif
                end else if (bit_cnt != 3'd7) begin
                    bit_cnt_nxt = bit_cnt_inc;
                    raw_valid   = 1'b1;
                    if (state == ST_SYNC) begin
                        raw_bit = SYNC_PATTERN[bit_cnt_inc];
                    end else begin
                        shift_reg_nxt = {1'b0, shift_reg[7:1]};
                        raw_bit       = shift_reg[1];
                    end
                end else if ((state == ST_SYNC) || (!cur_eop && hold_valid)) begin
                    state_nxt      = ST_DATA;
                    bit_cnt_nxt    = 3'd0;
                    shift_reg_nxt  = hold_data;
                    cur_eop_nxt    = hold_eop;
                    hold_valid_nxt = 1'b0;
                    raw_valid      = 1'b1;
                    raw_bit        = hold_data[0];
                end else begin
                    // Either the eop byte finished or upstream ran dry
                    state_nxt      = ST_EOP_SE0;
                    se0_second_nxt = 1'b0;
                    dp_nxt         = 1'b0;
                    oe_nxt         = 1'b1;
                    underrun_nxt   = ~cur_eop;
                end
            end
            ST_EOP_SE0: begin
                oe_nxt = 1'b1;
                if (!se0_second) begin
                    se0_second_nxt = 1'b1;
                    dp_nxt         = 1'b0;
                end else begin
                    state_nxt = ST_EOP_J;
                end
            end
            ST_EOP_J: begin
                // Leftovers (e.g. a byte caught on an underrun edge) are dropped
                state_nxt      = ST_IDLE;
                hold_valid_nxt = 1'b0;
                eop_taken_nxt  = 1'b0;
                line_j_nxt     = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (raw_valid) begin
            line_j_nxt = raw_bit ? enc_base : ~enc_base;
            dp_nxt     = line_j_nxt;
            dn_nxt     = ~line_j_nxt;
            oe_nxt     = 1'b1;
`ifdef USB_TX_BITSTUFF_EN
            ones_nxt   = raw_bit ? (ones_base + 3'd1) : 3'd0;
`endif
        end
    end

    // State and registered line outputs; reset forces an idle J line at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold_data   <= 8'h00;
            hold_eop    <= 1'b0;
            hold_valid  <= 1'b0;
            eop_taken   <= 1'b0;
            shift_reg   <= 8'h00;
            cur_eop     <= 1'b0;
            bit_cnt     <= 3'd0;
            se0_second  <= 1'b0;
            line_j      <= 1'b1;
            tx_dp       <= 1'b1;
            tx_dn       <= 1'b0;
            tx_oe       <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
            ones_cnt    <= 3'd0;
`endif
        end else begin
            state       <= state_nxt;
            hold_data   <= hold_data_nxt;
            hold_eop    <= hold_eop_nxt;
            hold_valid  <= hold_valid_nxt;
            eop_taken   <= eop_taken_nxt;
            shift_reg   <= shift_reg_nxt;
            cur_eop     <= cur_eop_nxt;
            bit_cnt     <= bit_cnt_nxt;
            se0_second  <= se0_second_nxt;
            line_j      <= line_j_nxt;
            tx_dp       <= dp_nxt;
            tx_dn       <= dn_nxt;
            tx_oe       <= oe_nxt;
            tx_underrun <= underrun_nxt;
`ifdef USB_TX_BITSTUFF_EN
            ones_cnt    <= ones_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - randomized bench checking the USB TX line against a bit-list model
`timescale 1ns/1ps
module tb_usb_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_to_sop, tx_to_eop, tx_to_valid, tx_to_ready;
    logic [7:0] tx_to_data;
    logic       tx_dp, tx_dn, tx_oe, tx_busy, tx_underrun;

    always #5 clk = ~clk;

    usb_tx_serializer dut (
        .clk(clk), .rst_n(rst_n),
        .tx_to_sop(tx_to_sop), .tx_to_eop(tx_to_eop), .tx_to_valid(tx_to_valid),
        .tx_to_ready(tx_to_ready), .tx_to_data(tx_to_data),
        .tx_dp(tx_dp), .tx_dn(tx_dn), .tx_oe(tx_oe),
        .tx_busy(tx_busy), .tx_underrun(tx_underrun)
    );

    // One expected line cycle; rdy 2 means ready is not checked
    typedef struct packed {
        logic       dp;
        logic       dn;
        logic       oe;
        logic       ur;
        logic [1:0] rdy;
    } cyc_t;

    cyc_t       exp_q[$];
    cyc_t       model_seq[$];
    logic [7:0] pkt_bytes[$];
    bit         pkt_eop;
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         cmp_en = 1'b0;
    int         oe_run = 0;
    int         last_oe_len = 0;
    int         ur_count = 0;

    // Line model: raw bit list -> stuffing -> NRZI -> EOP
    function automatic void build_packet(input logic [7:0] bytes[$], input bit with_eop);
        bit         raw[$];
        bit         st[$];
        int         ones;
        logic       lvl;
        logic [7:0] sync_b;
        logic [1:0] data_rdy;
        cyc_t       c;
        model_seq.delete();
        sync_b = 8'h80;
        for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
        foreach (bytes[k]) for (int i = 0; i < 8; i++) raw.push_back(bytes[k][i]);
        ones = 0;
        foreach (raw[k]) begin
            st.push_back(raw[k]);
            if (raw[k]) ones++; else ones = 0;
`ifdef USB_TX_BITSTUFF_EN
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
`endif
        end
        data_rdy = (bytes.size() == 1 && with_eop) ? 2'd0 : 2'd2;
        lvl = 1'b1;
        foreach (st[k]) begin
            if (!st[k]) lvl = ~lvl;
            c.dp = lvl; c.dn = ~lvl; c.oe = 1'b1; c.ur = 1'b0;
            c.rdy = (k < 8) ? 2'd0 : data_rdy;
            model_seq.push_back(c);
        end
        c.dp = 1'b0; c.dn = 1'b0; c.oe = 1'b1; c.ur = !with_eop; c.rdy = 2'd0;
        model_seq.push_back(c);
        c.ur = 1'b0;
        model_seq.push_back(c);
        c.dp = 1'b1;
        model_seq.push_back(c);
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic compare_cycle();
        cyc_t e;
        if (!cmp_en) begin
            oe_run = 0;
            return;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
            e.dp = 1'b1; e.dn = 1'b0; e.oe = 1'b0; e.ur = 1'b0; e.rdy = 2'd1;
        end
        n_cmp++;
        if (tx_dp !== e.dp || tx_dn !== e.dn || tx_oe !== e.oe || tx_busy !== e.oe ||
            tx_underrun !== e.ur || (e.rdy != 2'd2 && tx_to_ready !== e.rdy[0])) begin
            n_fail++;
            $display("FAIL line t=%0t got dp%b dn%b oe%b busy%b ur%b rdy%b want dp%b dn%b oe%b busy%b ur%b rdy%0d",
                     $time, tx_dp, tx_dn, tx_oe, tx_busy, tx_underrun, tx_to_ready,
                     e.dp, e.dn, e.oe, e.oe, e.ur, e.rdy);
        end
        if (tx_oe) oe_run++;
        else if (oe_run > 0) begin
            last_oe_len = oe_run;
            oe_run = 0;
        end
        if (tx_underrun) ur_count++;
    endtask

    // Offer one byte; a packet's expectation is queued at its sop handshake edge
    task automatic offer(input logic [7:0] d, input logic s, input logic e, input bit start, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        @(negedge clk);
        tx_to_data = d; tx_to_sop = s; tx_to_eop = e; tx_to_valid = 1'b1;
        while (!tx_to_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx_to_ready) begin
            @(posedge clk);
            ok = 1'b1;
            if (start) begin
                build_packet(pkt_bytes, pkt_eop);
                foreach (model_seq[i]) exp_q.push_back(model_seq[i]);
            end
            #1;
        end else begin
            check("offer_timeout", 0, 1);
        end
        tx_to_valid = 1'b0; tx_to_sop = 1'b0; tx_to_eop = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (tx_to_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic send_packet(input int gap_lo, input int gap_hi);
        bit ok;
        for (int k = 0; k < pkt_bytes.size(); k++) begin
            if (k > 0) begin
                wait_ready(ok);
                if (!ok) return;
                repeat ($urandom_range(gap_lo, gap_hi)) @(negedge clk);
            end
            offer(pkt_bytes[k], k == 0, pkt_eop && (k == pkt_bytes.size() - 1), k == 0, ok);
            if (!ok) return;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] ack_lv;
        int          mism;
        int          bad;
        int          ur_before;
        int          kind;
        int          nb;
        bit          ok;
        rst_n = 1'b0; tx_to_valid = 1'b0; tx_to_sop = 1'b0; tx_to_eop = 1'b0; tx_to_data = 8'h00;

        // Pin the model with hand-derived sequences
        ack_lv = 16'b0001_1011_0010_1010;
        pkt_bytes = '{8'hD2};
        build_packet(pkt_bytes, 1'b1);
        check("model_ack_len", model_seq.size(), 19);
        mism = 0;
        for (int i = 0; i < 16; i++)
            if (model_seq[i].dp !== ack_lv[i] || model_seq[i].dn !== ~ack_lv[i]) mism++;
        check("model_ack_levels", mism, 0);
        check("model_ack_eop", {model_seq[16].dp, model_seq[16].dn, model_seq[17].dp,
                                model_seq[17].dn, model_seq[18].dp, model_seq[18].dn}, 6'b000010);
        pkt_bytes = '{8'hFF};
        build_packet(pkt_bytes, 1'b1);
`ifdef USB_TX_BITSTUFF_EN
        check("model_ff_len", model_seq.size(), 20);
        check("model_ff_stuff", {model_seq[12].dp, model_seq[13].dp}, 2'b01);
`else
        check("model_ff_len", model_seq.size(), 19);
        check("model_ff_nostuff", {model_seq[12].dp, model_seq[13].dp}, 2'b00);
`endif
        pkt_bytes = '{8'hFC};
        build_packet(pkt_bytes, 1'b1);
`ifdef USB_TX_BITSTUFF_EN
        check("model_fc_len", model_seq.size(), 20);
`else
        check("model_fc_len", model_seq.size(), 19);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_vals", {tx_dp, tx_dn, tx_oe, tx_to_ready, tx_busy, tx_underrun}, 6'b100100);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // ACK
        last_oe_len = 0;
        pkt_bytes = '{8'hD2}; pkt_eop = 1'b1;
        send_packet(0, 0);
        wait_drain(); @(negedge clk); #1;
        check("ack_oe_len", last_oe_len, 19);

        // Mid-byte stuff
        last_oe_len = 0;
        pkt_bytes = '{8'hFF}; pkt_eop = 1'b1;
        send_packet(0, 0);
        wait_drain(); @(negedge clk); #1;
`ifdef USB_TX_BITSTUFF_EN
        check("ff_oe_len", last_oe_len, 20);
`else
        check("ff_oe_len", last_oe_len, 19);
`endif

        // Trailing stuff
        last_oe_len = 0;
        pkt_bytes = '{8'hFC}; pkt_eop = 1'b1;
        send_packet(0, 0);
        wait_drain(); @(negedge clk); #1;
`ifdef USB_TX_BITSTUFF_EN
        check("fc_oe_len", last_oe_len, 20);
`else
        check("fc_oe_len", last_oe_len, 19);
`endif

        // Token with upstream backpressure
        last_oe_len = 0;
        pkt_bytes = '{8'hE1, 8'h15, 8'h07}; pkt_eop = 1'b1;
        send_packet(2, 2);
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!tx_busy) break;
            if (tx_to_ready) bad++;
        end
        #1;
        check("token_ready_hold", bad, 0);
        wait_drain(); @(negedge clk); #1;
        check("token_oe_len", last_oe_len, 35);

        // Underrun
        last_oe_len = 0;
        ur_before = ur_count;
        pkt_bytes = '{8'hE1}; pkt_eop = 1'b0;
        send_packet(0, 0);
        wait_drain(); @(negedge clk); #1;
        check("underrun_oe_len", last_oe_len, 19);
        check("underrun_pulses", ur_count - ur_before, 1);

        // Reset during data bit3
        pkt_bytes = '{8'hD2}; pkt_eop = 1'b1;
        send_packet(0, 0);
        repeat (11) @(posedge clk);
        #2;
        cmp_en = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_vals", {tx_dp, tx_dn, tx_oe, tx_to_ready, tx_busy, tx_underrun}, 6'b100100);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        last_oe_len = 0;
        send_packet(0, 0);
        wait_drain(); @(negedge clk); #1;
        check("post_reset_ack_len", last_oe_len, 19);

        // Randomized packets, stray non-sop bytes and back-to-back starts
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 3);
            nb = $urandom_range(1, 4);
            pkt_bytes.delete();
            for (int i = 0; i < nb; i++)
                pkt_bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            pkt_eop = (kind != 0);
            if (kind == 3) offer(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, ok);
            send_packet(0, 3);
            wait_drain();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
